// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the ownership state enum, default sizing and the CPU address check.
package dmem_pkg;

    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        HOST_XFER = 2'd1,
        HOST_ACK  = 2'd2
    } dmem_state_e;

    localparam int DMEM_AW    = 8;
    localparam int DMEM_ERR_W = 16;

    // A CPU byte address is usable only if it is word aligned and every bit
    // above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        logic [31:0] w_hi;
        w_hi = addr >> (aw + 2);
        return (w_hi == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset so they survive a controller reset.
module dmem_array #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [2**AW];

    // Write port: commit on the rising edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: CPU M-stage data port plus a host load/dump port.
// The host borrows the array for two cycles, stalling the CPU meanwhile.
// Optional macro DMEM_ERR_CNT_EN adds a saturating address-error counter.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  CPU_OWN   | CPU reads/writes the array; host_req starts a transaction
//  HOST_XFER | host owns the array; host write or read capture at edge
//  HOST_ACK  | host_ack pulse; CPU still stalled; returns to CPU_OWN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int ERR_W = DMEM_ERR_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_cpu_addr,
    input  logic [31:0]      i_cpu_wdata,
    input  logic             i_cpu_we,
    output logic [31:0]      o_cpu_rdata,
    output logic             o_cpu_stall,
    input  logic             i_host_req,
    input  logic             i_host_we,
    input  logic [AW-1:0]    i_host_addr,
    input  logic [31:0]      i_host_wdata,
    output logic             o_host_ack,
    output logic [31:0]      o_host_rdata,
    output logic             o_addr_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    dmem_state_e r_state;
    logic        r_stall;
    logic        r_host_ack;
    logic [31:0] r_host_rdata;

    logic          w_in_range;
    logic          w_cpu_own;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_arr_addr;
    logic          w_arr_we;
    logic [31:0]   w_arr_wdata;
    logic [31:0]   w_arr_rdata;

    assign w_in_range = addr_in_range(i_cpu_addr, AW);
    assign w_cpu_own  = (r_state == CPU_OWN);
    assign w_idx      = i_cpu_addr[AW+1:2];

    // Array port mux: the host drives it only during HOST_XFER; the CPU write
    // path is gated off whenever the CPU does not own the array.
    always_comb begin
        w_arr_addr  = w_idx;
        w_arr_we    = i_cpu_we & w_in_range & w_cpu_own;
        w_arr_wdata = i_cpu_wdata;
        if (r_state == HOST_XFER) begin
            w_arr_addr  = i_host_addr;
            w_arr_we    = i_host_we;
            w_arr_wdata = i_host_wdata;
        end
    end

    dmem_array #(
        .AW (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign o_cpu_rdata = (w_cpu_own && w_in_range) ? w_arr_rdata : 32'd0;
    assign o_addr_err  = w_cpu_own & ~w_in_range;

    // Ownership FSM with registered stall/ack and captured host read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= CPU_OWN;
            r_stall      <= 1'b0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 32'd0;
        end else begin
            case (r_state)
                CPU_OWN: begin
                    r_host_ack <= 1'b0;
                    if (i_host_req) begin
                        r_state <= HOST_XFER;
                        r_stall <= 1'b1;
                    end
                end
                HOST_XFER: begin
                    if (!i_host_we) begin
                        r_host_rdata <= w_arr_rdata;
                    end
                    r_state    <= HOST_ACK;
                    r_stall    <= 1'b1;
                    r_host_ack <= 1'b1;
                end
                HOST_ACK: begin
                    r_state    <= CPU_OWN;
                    r_stall    <= 1'b0;
                    r_host_ack <= 1'b0;
                end
                default: begin
                    r_state    <= CPU_OWN;
                    r_stall    <= 1'b0;
                    r_host_ack <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_stall  = r_stall;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;

`ifdef DMEM_ERR_CNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    // Saturating count of cycles that carried a bad CPU address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (o_addr_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a word-array reference model.
module tb_dmem_responder;

    localparam int AW    = 8;
    localparam int ERR_W = 4;
    localparam int WORDS = 256;
    localparam int ERR_MAX = 15;

    logic             clk;
    logic             rst_n;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_we;
    logic [31:0]      cpu_rdata;
    logic             cpu_stall;
    logic             host_req;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [31:0]      host_wdata;
    logic             host_ack;
    logic [31:0]      host_rdata;
    logic             addr_err;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_mem   [WORDS];
    bit          m_known [WORDS];
    int          m_err;
    logic [31:0] m_hrd;

    dmem_responder #(
        .AW    (AW),
        .ERR_W (ERR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_we     (cpu_we),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_stall  (cpu_stall),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata),
        .o_addr_err   (addr_err),
        .o_err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // A byte address is usable if it lies within 4*WORDS bytes and is a multiple of 4.
    function automatic bit m_in_range(input logic [31:0] a);
        return (a < 32'(WORDS * 4)) && ((a % 4) == 0);
    endfunction

    function automatic logic [31:0] m_err_exp();
`ifdef DMEM_ERR_CNT_EN
        return 32'(m_err);
`else
        return 32'd0;
`endif
    endfunction

    function automatic void m_note_err(input logic [31:0] a);
        if (!m_in_range(a) && m_err < ERR_MAX) m_err++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle in CPU_OWN: check load data and error flag, then commit.
    task automatic cpu_cycle(input logic [31:0] a, input logic [31:0] d, input logic we);
        int idx;
        cpu_addr = a; cpu_wdata = d; cpu_we = we;
        #1;
        idx = int'(a / 4);
        if (m_in_range(a)) begin
            if (m_known[idx]) chk("cpu_rdata", cpu_rdata, m_mem[idx]);
            chk("addr_err_ok", {31'd0, addr_err}, 32'd0);
        end else begin
            chk("cpu_rdata_bad", cpu_rdata, 32'd0);
            chk("addr_err_bad", {31'd0, addr_err}, 32'd1);
        end
        tick();
        if (we && m_in_range(a)) begin
            m_mem[idx] = d;
            m_known[idx] = 1'b1;
        end
        m_note_err(a);
        cpu_we = 1'b0;
        cpu_addr = 32'd0;
        chk("err_cnt", {28'd0, err_cnt}, m_err_exp());
        chk("stall_idle", {31'd0, cpu_stall}, 32'd0);
    endtask

    // Full host transaction; the CPU may store in the request cycle and
    // attempts illegal traffic during both stalled cycles.
    task automatic host_txn(input logic hwe, input logic [AW-1:0] ha, input logic [31:0] hd,
                            input logic cwe, input logic [31:0] ca, input logic [31:0] cd);
        host_req = 1'b1; host_we = hwe; host_addr = ha; host_wdata = hd;
        cpu_addr = ca; cpu_wdata = cd; cpu_we = cwe;
        #1;
        chk("req_stall", {31'd0, cpu_stall}, 32'd0);
        chk("req_ack", {31'd0, host_ack}, 32'd0);
        tick();
        if (cwe && m_in_range(ca)) begin
            m_mem[int'(ca / 4)] = cd;
            m_known[int'(ca / 4)] = 1'b1;
        end
        m_note_err(ca);
        cpu_addr = 32'h0000_00FC; cpu_wdata = ~m_mem[63]; cpu_we = 1'b1;
        #1;
        chk("xfer_stall", {31'd0, cpu_stall}, 32'd1);
        chk("xfer_ack", {31'd0, host_ack}, 32'd0);
        chk("xfer_rdata", cpu_rdata, 32'd0);
        chk("xfer_err", {31'd0, addr_err}, 32'd0);
        tick();
        if (hwe) begin
            m_mem[ha] = hd;
            m_known[ha] = 1'b1;
        end else begin
            m_hrd = m_mem[ha];
        end
        cpu_addr = 32'h0000_0401; cpu_we = 1'b1;
        #1;
        chk("ack_stall", {31'd0, cpu_stall}, 32'd1);
        chk("ack_pulse", {31'd0, host_ack}, 32'd1);
        chk("ack_err", {31'd0, addr_err}, 32'd0);
        chk("ack_hrdata", host_rdata, m_hrd);
        tick();
        host_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
        chk("done_stall", {31'd0, cpu_stall}, 32'd0);
        chk("done_ack", {31'd0, host_ack}, 32'd0);
        chk("done_hrdata", host_rdata, m_hrd);
        chk("done_err_cnt", {28'd0, err_cnt}, m_err_exp());
    endtask

    initial begin
        logic [31:0] ra;
        int          kind;

        rst_n = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 32'd0;
        m_err = 0; m_hrd = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            m_mem[i] = 32'd0;
            m_known[i] = 1'b0;
        end

        // Reset state
        tick(); tick();
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ack", {31'd0, host_ack}, 32'd0);
        chk("rst_hrdata", host_rdata, 32'd0);
        chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill every word so later reads are fully predicted
        for (int i = 0; i < WORDS; i++) cpu_cycle(32'(i * 4), $urandom, 1'b1);

        // CPU store then load
        cpu_cycle(32'h10, 32'hDEAD_BEEF, 1'b1);
        cpu_addr = 32'h10;
        #1;
        chk("t1_load", cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_err", {31'd0, addr_err}, 32'd0);
        tick();

        // Host write, then CPU load of the same word
        host_txn(1'b1, 8'd5, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
        cpu_addr = 32'h14;
        #1;
        chk("t2_load", cpu_rdata, 32'h1234_5678);
        tick();

        // CPU store wins in the request cycle; host read sees it
        host_txn(1'b0, 8'd8, 32'd0, 1'b1, 32'h20, 32'hA5A5_A5A5);
        chk("t3_hrdata", host_rdata, 32'hA5A5_A5A5);

        // Out-of-range and misaligned stores
        cpu_cycle(32'h0400, 32'hFFFF_FFFF, 1'b1);
        cpu_cycle(32'h0002, 32'hFFFF_FFFF, 1'b1);
`ifdef DMEM_ERR_CNT_EN
        chk("t4_err_cnt", {28'd0, err_cnt}, 32'd2);
`else
        chk("t4_err_cnt", {28'd0, err_cnt}, 32'd0);
`endif
        cpu_cycle(32'h0000, 32'd0, 1'b0);

        // Saturation: 2**ERR_W + 3 error cycles
        for (int i = 0; i < 19; i++) cpu_cycle(32'h0800 + 32'(i * 4), 32'd0, 1'b0);
`ifdef DMEM_ERR_CNT_EN
        chk("t6_sat", {28'd0, err_cnt}, 32'd15);
`else
        chk("t6_sat", {28'd0, err_cnt}, 32'd0);
`endif

        // Reset during HOST_XFER of a host write
        cpu_cycle(32'h24, 32'h0BAD_F00D, 1'b1);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd9; host_wdata = 32'hFFFF_0000;
        tick();
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        chk("t5_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t5_ack", {31'd0, host_ack}, 32'd0);
        tick();
        m_err = 0; m_hrd = 32'd0;
        chk("t5_ack2", {31'd0, host_ack}, 32'd0);
        chk("t5_hrdata", host_rdata, 32'd0);
        chk("t5_err_cnt", {28'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        cpu_addr = 32'h24;
        #1;
        chk("t5_keep", cpu_rdata, 32'h0BAD_F00D);
        tick();

        // Randomized mix of CPU and host traffic
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                host_txn(1'($urandom), 8'($urandom), $urandom,
                         1'($urandom), 32'($urandom_range(0, 255)) * 4, $urandom);
            end else begin
                case ($urandom_range(0, 5))
                    0: ra = $urandom;
                    1: ra = 32'($urandom_range(0, 1023));
                    default: ra = 32'($urandom_range(0, 255)) * 4;
                endcase
                cpu_cycle(ra, $urandom, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
